// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
package fetch_pkg;

    localparam int              WIDTH    = 32;
    localparam logic [31:0]     PC_STEP  = 32'd4;
    localparam logic [31:0]     RESET_PC = 32'h0000_0000;

    // One buffered instruction together with the address it was fetched from.
    typedef struct packed {
        logic [WIDTH-1:0] pc;
        logic [WIDTH-1:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with a single-cycle flush; used for both the
// in-flight address queue and the prefetch data queue of fetch_unit.
// Pushes into a full queue and pops from an empty one are ignored.
module fetch_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush_i,
    input  logic                       push_i,
    input  logic [W-1:0]               push_data_i,
    input  logic                       pop_i,
    output logic [W-1:0]               head_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);
    import fetch_pkg::*;

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          push_ok_s;
    logic          pop_ok_s;

    assign push_ok_s = push_i & (count_q != CW'(DEPTH));
    assign pop_ok_s  = pop_i & (count_q != {CW{1'b0}});
    assign head_o    = mem_q[rd_ptr_q];
    assign count_o   = count_q;

    // Storage, pointers and occupancy; flush empties the queue but keeps storage.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            count_q  <= {CW{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {W{1'b0}};
            end
        end else if (flush_i) begin
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            count_q  <= {CW{1'b0}};
        end else begin
            if (push_ok_s) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_q + CW'(push_ok_s) - CW'(pop_ok_s);
        end
    end

endmodule

// File: rtl/fetch_unit_chk.sv
// Protocol checker for fetch_unit: memory must never return a word
// while no request is outstanding.
module fetch_unit_chk (
    input logic clk,
    input logic reset,
    input logic resp_valid_i,
    input logic idle_i
);

    a_resp_needs_outstanding: assert property (
        @(posedge clk) disable iff (!reset) !(resp_valid_i && idle_i)
    );

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: owns the fetch PC, issues word requests to
// instruction memory under a credit limit, buffers returned words with their
// PCs and hands them to decode. A redirect restarts fetch at a new target and
// marks every request still in flight as one to be discarded on return.
module fetch_unit #(
    parameter int               WIDTH    = fetch_pkg::WIDTH,
    parameter int               DEPTH    = 2,
    parameter logic [WIDTH-1:0] RESET_PC = fetch_pkg::RESET_PC
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             redirect,
    input  logic [WIDTH-1:0] redirect_pc,
    output logic             imem_req_valid,
    output logic [WIDTH-1:0] imem_req_addr,
    input  logic             imem_req_ready,
    input  logic             imem_resp_valid,
    input  logic [WIDTH-1:0] imem_resp_data,
    output logic             inst_valid,
    input  logic             inst_ready,
    output logic [WIDTH-1:0] inst,
    output logic [WIDTH-1:0] inst_pc
);
    import fetch_pkg::*;

    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic [CW-1:0]    outstanding_q, outstanding_d;
    logic [CW-1:0]    drop_q, drop_d;
    logic [CW-1:0]    aq_count_s, dq_count_s;
    logic [CW:0]      credit_used_s;
    logic [WIDTH-1:0] aq_head_s;
    logic [WIDTH-1:0] redirect_aligned_s;
    fetch_entry_t     dq_push_s, dq_head_s;
    logic             accept_s, resp_any_s, resp_live_s, resp_drop_s, consume_s;
    logic             outs_idle_s;

    // Live requests plus buffered words must leave room in the data queue.
    assign credit_used_s  = {1'b0, outstanding_q} - {1'b0, drop_q} + {1'b0, dq_count_s};
    assign imem_req_valid = credit_used_s < (CW+1)'(DEPTH);
    assign imem_req_addr  = fetch_pc_q;

    assign accept_s    = imem_req_valid & imem_req_ready;
    assign outs_idle_s = (outstanding_q == {CW{1'b0}});
    assign resp_any_s  = imem_resp_valid & ~outs_idle_s;
    assign resp_drop_s = resp_any_s & (drop_q != {CW{1'b0}});
    assign resp_live_s = resp_any_s & (drop_q == {CW{1'b0}}) & (aq_count_s != {CW{1'b0}});

    assign inst_valid = (dq_count_s != {CW{1'b0}});
    assign consume_s  = inst_valid & inst_ready;
    assign inst       = dq_head_s.inst;
    assign inst_pc    = dq_head_s.pc;

    assign redirect_aligned_s = redirect_pc & ~{{(WIDTH-2){1'b0}}, 2'b11};
    assign dq_push_s          = '{pc: aq_head_s, inst: imem_resp_data};

    // Next fetch PC, in-flight count and discard count; redirect overrides all.
    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        drop_d        = drop_q;
        outstanding_d = outstanding_q + CW'(accept_s) - CW'(resp_any_s);
        if (redirect) begin
            fetch_pc_d = redirect_aligned_s;
            drop_d     = outstanding_d;
        end else begin
            if (accept_s) begin
                fetch_pc_d = fetch_pc_q + WIDTH'(PC_STEP);
            end else begin
                fetch_pc_d = fetch_pc_q;
            end
            if (resp_drop_s) begin
                drop_d = drop_q - CW'(1);
            end else begin
                drop_d = drop_q;
            end
        end
    end

    // Fetch PC and counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc_q    <= RESET_PC;
            outstanding_q <= {CW{1'b0}};
            drop_q        <= {CW{1'b0}};
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
        end
    end

    // PCs of requests whose responses will be kept, in issue order.
    fetch_fifo #(.W(WIDTH), .DEPTH(DEPTH)) u_addr_q (
        .clk         (clk),
        .reset       (reset),
        .flush_i     (redirect),
        .push_i      (accept_s),
        .push_data_i (fetch_pc_q),
        .pop_i       (resp_live_s),
        .head_o      (aq_head_s),
        .count_o     (aq_count_s)
    );

    // Returned instructions waiting for decode.
    fetch_fifo #(.W($bits(fetch_entry_t)), .DEPTH(DEPTH)) u_data_q (
        .clk         (clk),
        .reset       (reset),
        .flush_i     (redirect),
        .push_i      (resp_live_s),
        .push_data_i (dq_push_s),
        .pop_i       (consume_s),
        .head_o      (dq_head_s),
        .count_o     (dq_count_s)
    );

    fetch_unit_chk u_chk (
        .clk          (clk),
        .reset        (reset),
        .resp_valid_i (imem_resp_valid),
        .idle_i       (outs_idle_s)
    );

endmodule
